// File: rtl/fetch_controller_if.sv
// Fetch bus bundle: instruction-memory index/data and the valid/ready queue head toward decode.
`timescale 1ns/1ps
interface fetch_controller_if #(
  parameter int unsigned DATA_BITS = 32
);
  logic [DATA_BITS-1:0] imem_index;
  logic [DATA_BITS-1:0] imem_instruction;
  logic                 if_valid;
  logic [DATA_BITS-1:0] if_instruction;
  logic [DATA_BITS-1:0] if_index;
  logic                 if_ready;

  modport master (
    output imem_index,
    input  imem_instruction,
    output if_valid,
    output if_instruction,
    output if_index,
    input  if_ready
  );

  modport slave (
    input  imem_index,
    output imem_instruction,
    input  if_valid,
    input  if_instruction,
    input  if_index,
    output if_ready
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: issues word indices to a 1-cycle synchronous IMEM,
// buffers returned words in a 2-entry FIFO and presents them to decode via valid/ready.
`timescale 1ns/1ps
module fetch_controller #(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned IMEM_SIZE = 128,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 redirect_valid,
  input  logic [DATA_BITS-1:0] redirect_index,
  fetch_controller_if.master   bus,
  output logic                 fault,
  output logic                 busy
);

  localparam logic [DATA_BITS-1:0] LAST_IDX  = DATA_BITS'(IMEM_SIZE - 1);
  localparam logic [DATA_BITS-1:0] RESET_IDX = DATA_BITS'(RESET_PC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT,
    S_FAULT
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_BITS-1:0] inflight_idx_q, inflight_idx_d;
  logic                 inflight_q, inflight_d;

  logic [DATA_BITS-1:0] q_instr [2];
  logic [DATA_BITS-1:0] q_idx   [2];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [1:0]           count_q;

  logic                 head_valid;
  logic                 pop, push, issue, redir, target_ok, credit;
  logic [2:0]           occupancy;
  logic [DATA_BITS-1:0] next_pc;

  assign head_valid = (count_q != 2'd0);
  assign pop        = head_valid & bus.if_ready;
  assign redir      = redirect_valid & ((state_q == S_RUN) | (state_q == S_HALT));
  assign target_ok  = (redirect_index <= LAST_IDX);

  // Words already owed to the queue (stored + in flight) minus the one leaving now.
  assign occupancy  = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign credit     = (occupancy < 3'd2);

  assign issue      = (state_q == S_RUN) & ~halt & ~redirect_valid & credit;
  assign push       = inflight_q & ~redir;
  assign next_pc    = (fetch_pc_q == LAST_IDX) ? '0 : fetch_pc_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      fetch_pc_q     <= RESET_IDX;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      inflight_q     <= inflight_d;
      inflight_idx_q <= inflight_idx_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    inflight_d     = issue;
    inflight_idx_d = inflight_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          fetch_pc_d = RESET_IDX;
        end
      end
      S_RUN: begin
        if (redir && !target_ok) state_d = S_FAULT;
        else if (halt)           state_d = S_HALT;
      end
      S_HALT: begin
        if (redir && !target_ok)  state_d = S_FAULT;
        else if (start && !halt)  state_d = S_RUN;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect never coincides with an issue, so the two pc updates are exclusive.
    if (redir && target_ok) begin
      fetch_pc_d = redirect_index;
    end else if (issue) begin
      fetch_pc_d     = next_pc;
      inflight_idx_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        q_instr[i] <= '0;
        q_idx[i]   <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (redir) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        q_instr[wr_ptr_q] <= bus.imem_instruction;
        q_idx[wr_ptr_q]   <= inflight_idx_q;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  assign bus.imem_index     = fetch_pc_q;
  assign bus.if_valid       = head_valid;
  assign bus.if_instruction = head_valid ? q_instr[rd_ptr_q] : '0;
  assign bus.if_index       = head_valid ? q_idx[rd_ptr_q]   : '0;

  assign fault = (state_q == S_FAULT);
  assign busy  = (state_q == S_RUN) | inflight_q | head_valid;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count_q == 2'd2));

endmodule
